ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, default 16, data width of the RAM word and the instruction width.
REQ-002 Parameter AW, default 8, RAM address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 f_req  input  1  fetch request; fetch is read-only.
REQ-006 f_addr  input  AW  fetch address, taken from the PC.
REQ-007 f_ack  output  1  one-cycle pulse when the fetch completes; rdata is valid in the same cycle.
REQ-008 d_req  input  1  data request from the LDR/STR sequencer.
REQ-009 d_we  input  1  1 = write (STR), 0 = read (LDR).
REQ-010 d_addr  input  AW  data address.
REQ-011 d_wdata  input  DW  store data.
REQ-012 d_ack  output  1  one-cycle pulse when the data access completes; for reads, rdata is valid in the same cycle.
REQ-013 rdata  output  DW  read data returned to the current winner.
REQ-014 mem_addr  output  AW  RAM address.
REQ-015 mem_write  output  1  RAM write enable.
REQ-016 mem_din  output  DW  RAM write data.
REQ-017 mem_dout  input  DW  RAM read data, valid one cycle after mem_addr is presented.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 grant_d  output  1  identifies the current or most recent winner: 1 = data, 0 = fetch.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; one transaction every 3 cycles, with no back-to-back pipelining.
REQ-021 IDLE: if f_req or d_req is high, select a winner per REQ-026/REQ-027.
  - Latch the winner's address; for data, also latch we and wdata.
  - Set grant_d to the winner and go to ACCESS.
  - Otherwise stay in IDLE.
REQ-022 ACCESS: drive mem_addr = latched address and mem_write = latched we (always 0 for fetch), then go to RESP.
REQ-023 RESP: capture mem_dout into rdata.
  - Pulse the winner's ack for exactly 1 cycle; mem_write = 0.
  - Go to IDLE.
  - rdata holds its value until the next RESP.
REQ-024 mem_din SHALL equal the latched wdata at all times; outside ACCESS, mem_addr holds the last latched address.
REQ-025 Requests are sampled only in IDLE.
  - A req that drops after the grant does not cancel the transaction; the ack is still issued.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
REQ-026 Both req high in IDLE, ARB_RR_EN undefined: data wins (fixed priority).
REQ-027 Both req high in IDLE, ARB_RR_EN defined: the winner is the requester opposite to grant_d.
REQ-028 Single requester: that requester wins regardless of policy.
REQ-029 f_ack and d_ack SHALL never be high in the same cycle; mem_write SHALL be high only in ACCESS with the data winner and d_we latched as 1.
REQ-030 Inputs changing during ACCESS or RESP SHALL not affect mem_addr, mem_write or mem_din of the in-flight transaction.

Reset
REQ-031 reset low at a rising edge: state = IDLE, f_ack = d_ack = 0, mem_write = 0, busy = 0, grant_d = 0, rdata = 0, latched address/data/we = 0.
REQ-032 Reset asserted in ACCESS or RESP aborts the transaction: no ack is issued, and mem_write is 0 from the next edge.
REQ-033 Requests are ignored while reset is low; arbitration resumes on the first edge with reset high.

Configuration
REQ-034 Macro ARB_RR_EN defined: round-robin between fetch and data per REQ-027, so after reset the first contended grant goes to data.
REQ-035 Macro ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-026; the round-robin logic is absent from the design.

Verification
REQ-036 Reset, then f_req = 1 with f_addr = 0x05 and RAM[5] = 0xD103 -> mem_addr = 0x05 in cycle 2, f_ack and rdata = 0xD103 in cycle 3, busy = 0 in cycle 4.
REQ-037 d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0xBEEF -> mem_write = 1 for exactly one cycle with mem_addr = 0x20; d_ack in the next cycle; a following fetch of 0x20 returns 0xBEEF.
REQ-038 f_req and d_req both held high continuously:
  - Without ARB_RR_EN -> only d_ack pulses, every 3 cycles.
  - With ARB_RR_EN -> grants alternate D, F, D, F.
REQ-039 reset driven low in the ACCESS cycle of a write to 0x30 -> no d_ack; mem_write = 0 after the edge; busy = 0; the bench confirms whether RAM[0x30] was written.
REQ-040 d_addr and d_wdata changed to 0x44/0x1234 during ACCESS of a write to 0x40/0xAAAA -> RAM[0x40] = 0xAAAA, RAM[0x44] unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single synchronous RAM port between an instruction
// fetch unit (read-only) and the LDR/STR data sequencer.
//
// Each transaction takes three cycles: IDLE (arbitrate and latch the
// request), ACCESS (present the address and write enable), RESP (return
// read data and pulse the winner's ack). There is no pipelining between
// transactions.
//
// Configuration macro ARB_RR_EN:
//   undefined - data always wins when both sides request (fixed priority).
//   defined   - contended grants alternate, starting with data after reset.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   f_req, f_addr     fetch request and address
//   f_ack             one-cycle fetch completion pulse (rdata valid)
//   d_req, d_we       data request; 1 = store, 0 = load
//   d_addr, d_wdata   data address and store data
//   d_ack             one-cycle data completion pulse (rdata valid on loads)
//   rdata             read data for the current/most recent winner
//   mem_addr          RAM address (holds the last latched address)
//   mem_write         RAM write enable (ACCESS of a store only)
//   mem_din           RAM write data (always the latched store data)
//   mem_dout          RAM read data, one cycle after mem_addr
//   busy              high whenever the arbiter is not in IDLE
//   grant_d           current/most recent winner: 1 = data, 0 = fetch
module ram_arbiter #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          grant_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          grant_d_q, grant_d_d;
  logic          pick_data;
  logic          in_resp;

  // Winner selection when at least one side requests. A lone requester
  // always wins; only the contended case depends on the policy.
  always_comb begin
`ifdef ARB_RR_EN
    pick_data = d_req & (~f_req | ~grant_d_q);
`else
    pick_data = d_req;
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    grant_d_d = grant_d_q;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          grant_d_d = pick_data;
          state_d   = ACCESS;
          if (pick_data) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            // Fetch is read-only; store data keeps its last value.
            addr_d = f_addr;
            we_d   = 1'b0;
          end
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rdata_d = mem_dout;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      grant_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      grant_d_q <= grant_d_d;
    end
  end

  // Outputs come from latched state only, so request inputs moving during
  // ACCESS/RESP cannot disturb the in-flight RAM access.
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign mem_write = (state_q == ACCESS) && we_q;
  assign busy      = (state_q != IDLE);
  assign grant_d   = grant_d_q;

  // An ack is suppressed when reset is asserted during RESP, so an aborted
  // transaction never reports completion.
  assign in_resp = (state_q == RESP) && reset;
  assign f_ack   = in_resp && !grant_d_q;
  assign d_ack   = in_resp && grant_d_q;

  // RAM data arrives during RESP; forward it so it is valid with the ack,
  // then hold the captured copy until the next RESP.
  assign rdata = (state_q == RESP) ? mem_dout : rdata_q;

endmodule
